// File: rtl/sfrl_pkg.sv
// Shared types, widths and the 8-bit LFSR word expansion for the sfrl arbiter.
package sfrl_pkg;

  localparam int SEED_W = 8;
  localparam int RND_W  = 32;
  localparam logic [SEED_W-1:0] SEED_ZERO_SUB = 8'h01;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  // An all-zero seed would lock the LFSR, so it is replaced on load.
  function automatic logic [SEED_W-1:0] seed_fix(input logic [SEED_W-1:0] s);
    return (s == '0) ? SEED_ZERO_SUB : s;
  endfunction

  function automatic logic [RND_W-1:0] lfsr_expand(input logic [SEED_W-1:0] seed);
    logic [SEED_W-1:0] s;
    logic [RND_W-1:0]  w;
    logic              fb;
    s = seed;
    w = '0;
    for (int unsigned i = 0; i < RND_W; i++) begin
      w[i] = s[0];
      fb   = s[0] ^ s[1];
      s    = {fb, s[SEED_W-1:1]};
    end
    return w;
  endfunction

endpackage

// File: rtl/sfrl_if.sv
// Requester-side bus of the sfrl arbiter: requests, seed configuration, acks and words.
interface sfrl_if #(
  parameter int NUM_REQ = 4
);
  import sfrl_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               seed_load;
  logic [SEED_W-1:0]  seed_in;
  logic [NUM_REQ-1:0] ack;
  logic               rnd_valid;
  logic [RND_W-1:0]   rnd_out;
  logic               busy;
  logic [SEED_W-1:0]  seed_cur;

  modport master (
    output req, seed_load, seed_in,
    input  ack, rnd_valid, rnd_out, busy, seed_cur
  );

  modport slave (
    input  req, seed_load, seed_in,
    output ack, rnd_valid, rnd_out, busy, seed_cur
  );

endinterface

// File: rtl/sfrl_gen32.sv
// Registered expansion of an 8-bit seed into a 32-bit LFSR word; captures when enabled.
module sfrl_gen32
  import sfrl_pkg::*;
(
  input  logic              clk,
  input  logic              en,
  input  logic [SEED_W-1:0] seed,
  output logic [RND_W-1:0]  word
);

  always_ff @(posedge clk) begin
    if (en) word <= lfsr_expand(seed);
  end

endmodule

// File: rtl/sfrl_arbiter.sv
// Round-robin sharing of one LFSR word generator among NUM_REQ requesters,
// with seed chaining after each delivery and deferred seed loads during service.
module sfrl_arbiter
  import sfrl_pkg::*;
#(
  parameter int              NUM_REQ    = 4,
  parameter logic [SEED_W-1:0] SEED_RESET = 8'hA5
) (
  input  logic   clk,
  input  logic   rst_n,
  sfrl_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gnt_id;
  logic [IDX_W-1:0]   pick;
  logic [SEED_W-1:0]  seed;
  logic               pend;
  logic [SEED_W-1:0]  pend_val;
  logic [NUM_REQ-1:0] ack;
  logic               rnd_valid;
  logic               busy;
  logic [RND_W-1:0]   gen_word;

  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   p);
    int unsigned j;
    logic        found;
    logic [IDX_W-1:0] sel;
    found = 1'b0;
    sel   = p;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      j = (32'(p) + k) % NUM_REQ;
      if (!found && r[j]) begin
        found = 1'b1;
        sel   = IDX_W'(j);
      end
    end
    return sel;
  endfunction

  always_comb pick = rr_pick(bus.req, ptr);

  sfrl_gen32 u_gen (
    .clk  (clk),
    .en   (state == ISSUE),
    .seed (seed),
    .word (gen_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= IDX_W'(NUM_REQ - 1);
      gnt_id    <= '0;
      seed      <= SEED_RESET;
      pend      <= 1'b0;
      pend_val  <= '0;
      ack       <= '0;
      rnd_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ack       <= '0;
      rnd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.seed_load) begin
            seed <= seed_fix(bus.seed_in);
            pend <= 1'b0;
          end else if (pend) begin
            seed <= pend_val;
            pend <= 1'b0;
          end else if (|bus.req) begin
            gnt_id <= pick;
            state  <= ISSUE;
            busy   <= 1'b1;
          end
        end
        ISSUE: begin
          ack[gnt_id] <= 1'b1;
          rnd_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          ptr   <= gnt_id;
          seed  <= gen_word[RND_W-1:RND_W-SEED_W];
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      // Loads during service are parked and applied in the following IDLE,
      // so they override the seed chained at the end of DONE.
      if (state != IDLE && bus.seed_load) begin
        pend     <= 1'b1;
        pend_val <= seed_fix(bus.seed_in);
      end
    end
  end

  assign bus.ack       = ack;
  assign bus.rnd_valid = rnd_valid;
  assign bus.rnd_out   = rnd_valid ? gen_word : '0;
  assign bus.busy      = busy;
  assign bus.seed_cur  = seed;

endmodule

// File: tb/tb_sfrl_arbiter.sv
// Directed bench for sfrl_arbiter: reset, round-robin order, seed load/zero/deferral, reset mid-service.
module tb_sfrl_arbiter;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [7:0]  seed_m;
  logic [31:0] exp_word;

  sfrl_if #(.NUM_REQ(4)) bus ();

  sfrl_arbiter #(.NUM_REQ(4), .SEED_RESET(8'hA5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word from the recurrence r[i+8] = r[i] ^ r[i+1] with r[7:0] = seed.
  function automatic logic [31:0] gen_model(input logic [7:0] seed);
    logic [31:0] r;
    r = '0;
    r[7:0] = seed;
    for (int i = 8; i < 32; i++) r[i] = r[i-8] ^ r[i-7];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts in IDLE with req applied; ends in the IDLE cycle after DONE.
  task automatic service(input logic [3:0] exp_ack, input bit drop, input string tag);
    int n;
    n = 0;
    while (bus.rnd_valid !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'd2);
    check({tag, " ack"}, 32'(bus.ack), 32'(exp_ack));
    exp_word = gen_model(seed_m);
    check({tag, " rnd_out"}, bus.rnd_out, exp_word);
    seed_m = exp_word[31:24];
    if (drop) bus.req = '0;
    tick();
    check({tag, " ack pulse"}, 32'(bus.ack), 32'd0);
    check({tag, " seed chain"}, 32'(bus.seed_cur), 32'(seed_m));
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.seed_load = 1'b0;
    bus.seed_in   = '0;
    tick();
    tick();
    check("rst ack", 32'(bus.ack), 32'd0);
    check("rst rnd_valid", 32'(bus.rnd_valid), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst seed_cur", 32'(bus.seed_cur), 32'hA5);
    check("rst rnd_out", bus.rnd_out, 32'd0);
    rst_n = 1'b1;
    tick();

    // Round robin with all requests held: 0,1,2,3,0.
    seed_m  = 8'hA5;
    bus.req = 4'b1111;
    service(4'b0001, 1'b0, "rr0");
    service(4'b0010, 1'b0, "rr1");
    service(4'b0100, 1'b0, "rr2");
    service(4'b1000, 1'b0, "rr3");
    service(4'b0001, 1'b1, "rr4");

    // Seed load then a single request.
    bus.seed_load = 1'b1;
    bus.seed_in   = 8'h01;
    tick();
    bus.seed_load = 1'b0;
    check("load seed_cur", 32'(bus.seed_cur), 32'h01);
    check("load busy", 32'(bus.busy), 32'd0);
    seed_m  = 8'h01;
    bus.req = 4'b0100;
    service(4'b0100, 1'b1, "single");
    check("single word const", exp_word, 32'hE141_8101);

    // Zero seed is stored as 8'h01.
    bus.seed_load = 1'b1;
    bus.seed_in   = 8'h00;
    tick();
    bus.seed_load = 1'b0;
    check("zero seed_cur", 32'(bus.seed_cur), 32'h01);
    seed_m  = 8'h01;
    bus.req = 4'b0001;
    service(4'b0001, 1'b1, "zero");

    // Loads in ISSUE and DONE: word from old seed, later load wins afterwards.
    bus.req = 4'b0010;
    tick();
    check("defer busy", 32'(bus.busy), 32'd1);
    check("defer no valid", 32'(bus.rnd_valid), 32'd0);
    bus.seed_load = 1'b1;
    bus.seed_in   = 8'h99;
    tick();
    bus.seed_in = 8'h3C;
    exp_word = gen_model(seed_m);
    check("defer ack", 32'(bus.ack), 32'b0010);
    check("defer rnd_out", bus.rnd_out, exp_word);
    bus.req = '0;
    tick();
    bus.seed_load = 1'b0;
    check("defer chained", 32'(bus.seed_cur), 32'(exp_word[31:24]));
    tick();
    check("defer applied", 32'(bus.seed_cur), 32'h3C);
    check("defer idle", 32'(bus.busy), 32'd0);

    // Load and request together: load first, grant a cycle later.
    bus.seed_load = 1'b1;
    bus.seed_in   = 8'hC3;
    bus.req       = 4'b0100;
    tick();
    bus.seed_load = 1'b0;
    check("sim busy", 32'(bus.busy), 32'd0);
    check("sim seed_cur", 32'(bus.seed_cur), 32'hC3);
    seed_m = 8'hC3;
    service(4'b0100, 1'b1, "sim");
    check("sim low byte", 32'(exp_word[7:0]), 32'hC3);

    // Reset in ISSUE, with a load parked in the same cycle.
    bus.req = 4'b1000;
    tick();
    check("mid busy", 32'(bus.busy), 32'd1);
    bus.seed_load = 1'b1;
    bus.seed_in   = 8'h77;
    rst_n = 1'b0;
    #1;
    check("mid ack", 32'(bus.ack), 32'd0);
    check("mid busy rst", 32'(bus.busy), 32'd0);
    check("mid seed_cur", 32'(bus.seed_cur), 32'hA5);
    bus.seed_load = 1'b0;
    tick();
    tick();
    check("mid no ack", 32'(bus.ack), 32'd0);
    check("mid no valid", 32'(bus.rnd_valid), 32'd0);
    rst_n   = 1'b1;
    bus.req = 4'b1111;
    seed_m  = 8'hA5;
    service(4'b0001, 1'b1, "post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
